// File: rtl/lsu_bridge.sv
// Load/store bridge between the MEM stage and a word-wide handshaked data bus.
// Narrows/replicates store data into byte lanes and extends load lanes back to 32 bits.
module lsu_bridge #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_sign,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        bus_err,
    output logic        exc_adel,
    output logic        exc_ades,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t        state_reg;
    logic [CW-1:0] count_reg;
    logic [1:0]    lane_reg;
    logic [1:0]    size_reg;
    logic          sign_reg;

    logic          bad_align;
    logic          in_idle;
    logic          accept;
    logic [3:0]    be_next;
    logic [31:0]   wdata_next;
    logic [7:0]    rbyte [4];
    logic [15:0]   rhalf;
    logic [31:0]   load_data;

    always_comb begin
        bad_align = 1'b0;
        case (req_size)
            2'b01:   bad_align = req_addr[0];
            2'b10:   bad_align = |req_addr[1:0];
            2'b11:   bad_align = 1'b1;
            default: bad_align = 1'b0;
        endcase
    end

    assign in_idle  = (state_reg == IDLE);
    assign accept   = in_idle & req_valid & ~bad_align;
    assign exc_adel = in_idle & req_valid & bad_align & ~req_we;
    assign exc_ades = in_idle & req_valid & bad_align & req_we;
    assign stall    = accept | (state_reg == BUSY);

    // Per-lane store packing and load byte selection (little-endian lanes).
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign be_next[gi] = (req_size == 2'b00) ? (req_addr[1:0] == 2'(gi)) :
                             (req_size == 2'b01) ? (req_addr[1] == (gi >= 2)) :
                                                   1'b1;
        assign wdata_next[8*gi +: 8] = (req_size == 2'b00) ? req_wdata[7:0] :
                                       (req_size == 2'b01) ? req_wdata[8*(gi%2) +: 8] :
                                                             req_wdata[8*gi +: 8];
        assign rbyte[gi] = bus_rdata[8*gi +: 8];
    end

    // Extension uses the size/sign/lane captured when the access was accepted.
    always_comb begin
        rhalf     = lane_reg[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        load_data = bus_rdata;
        case (size_reg)
            2'b00:   load_data = {{24{sign_reg & rbyte[lane_reg][7]}}, rbyte[lane_reg]};
            2'b01:   load_data = {{16{sign_reg & rhalf[15]}}, rhalf};
            default: load_data = bus_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            count_reg  <= '0;
            lane_reg   <= 2'b00;
            size_reg   <= 2'b00;
            sign_reg   <= 1'b0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_be     <= 4'b0000;
            bus_wdata  <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            bus_err    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        bus_req   <= 1'b1;
                        bus_we    <= req_we;
                        bus_addr  <= {req_addr[31:2], 2'b00};
                        bus_be    <= req_we ? be_next : 4'b0000;
                        bus_wdata <= req_we ? wdata_next : 32'd0;
                        lane_reg  <= req_addr[1:0];
                        size_reg  <= req_size;
                        sign_reg  <= req_sign;
                        count_reg <= '0;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus_ack) begin
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        resp_rdata <= bus_we ? 32'd0 : load_data;
                        state_reg  <= RESP;
                    end else if (count_reg == CW'(TIMEOUT_CYCLES - 1)) begin
                        bus_req    <= 1'b0;
                        resp_valid <= 1'b1;
                        bus_err    <= 1'b1;
                        resp_rdata <= '0;
                        state_reg  <= RESP;
                    end else begin
                        count_reg <= count_reg + CW'(1);
                    end
                end
                RESP: begin
                    resp_valid <= 1'b0;
                    bus_err    <= 1'b0;
                    resp_rdata <= '0;
                    state_reg  <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_bridge.sv
// Scoreboard bench for lsu_bridge: a driver queues expected bus/response records,
// a negedge monitor pops and compares them when the DUT raises bus_req or resp_valid.
module tb_lsu_bridge;
    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_sign = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        bus_ack = 1'b0;
    logic [31:0] bus_rdata = '0;
    logic        stall, resp_valid, bus_err, exc_adel, exc_ades, bus_req, bus_we;
    logic [31:0] resp_rdata, bus_addr, bus_wdata;
    logic [3:0]  bus_be;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } bus_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          stalls;
        int          reqs;
    } resp_t;

    bus_t  bus_q[$];
    resp_t resp_q[$];

    always #5 clk = ~clk;

    lsu_bridge #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_we(req_we), .req_size(req_size), .req_sign(req_sign),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .resp_valid(resp_valid), .resp_rdata(resp_rdata), .bus_err(bus_err),
        .exc_adel(exc_adel), .exc_ades(exc_ades),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: shift the addressed unit down to bit 0, mask to its width, then extend.
    function automatic logic [31:0] model_load(input logic [31:0] w, input logic [1:0] size,
                                               input logic [1:0] off, input logic sign);
        int          bits;
        int          shift;
        logic [31:0] mask;
        logic [31:0] v;
        if (size == 2'b10) return w;
        bits  = (size == 2'b00) ? 8 : 16;
        shift = (size == 2'b00) ? 8 * int'(off) : 16 * int'(off[1]);
        mask  = (32'd1 << bits) - 32'd1;
        v     = (w >> shift) & mask;
        if (sign && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [3:0] model_be(input logic [1:0] size, input logic [1:0] off);
        if (size == 2'b00) return 4'b0001 << off;
        if (size == 2'b01) return off[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] size, input logic [31:0] d);
        if (size == 2'b00) return {4{d[7:0]}};
        if (size == 2'b01) return {2{d[15:0]}};
        return d;
    endfunction

    // One aligned access; delay = idle BUSY cycles before ack (>= TO means timeout).
    task automatic do_access(input logic we, input logic [1:0] size, input logic sign,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input int delay);
        bus_t  b;
        resp_t r;
        int    busy;
        busy     = (delay < TO) ? delay + 1 : TO;
        b.addr   = {addr[31:2], 2'b00};
        b.we     = we;
        b.be     = we ? model_be(size, addr[1:0]) : 4'b0000;
        b.wdata  = model_wdata(size, wdata);
        r.err    = (delay >= TO);
        r.rdata  = (we || r.err) ? 32'd0 : model_load(rdata, size, addr[1:0], sign);
        r.stalls = 1 + busy;
        r.reqs   = busy;
        bus_q.push_back(b);
        resp_q.push_back(r);
        step();
        req_valid = 1'b1; req_we = we; req_size = size; req_sign = sign;
        req_addr = addr; req_wdata = wdata;
        step();
        req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom;
        req_sign = ~sign; req_size = 2'($urandom_range(0, 2));
        for (int i = 0; i < delay; i++) begin
            bus_rdata = $urandom;
            step();
        end
        bus_ack = 1'b1; bus_rdata = rdata;
        step();
        bus_ack = 1'b0; bus_rdata = $urandom;
        step();
    endtask

    task automatic do_misaligned(input logic we, input logic [1:0] size, input logic [31:0] addr);
        step();
        req_valid = 1'b1; req_we = we; req_size = size; req_addr = addr; req_wdata = $urandom;
        @(negedge clk);
        check("exc_adel", exc_adel, !we);
        check("exc_ades", exc_ades, we);
        check("mis_stall", stall, 0);
        step();
        req_valid = 1'b0;
        @(negedge clk);
        check("mis_bus_req", bus_req, 0);
    endtask

    // Monitor
    int   stall_run = 0;
    int   req_run = 0;
    logic req_prev = 1'b0;
    always @(negedge clk) begin
        if (reset) begin
            stall_run = 0;
            req_run   = 0;
            req_prev  = 1'b0;
        end else begin
            if (bus_req && !req_prev) begin
                if (bus_q.size() == 0) begin
                    check("unexpected_bus_req", 1, 0);
                end else begin
                    bus_t b;
                    b = bus_q.pop_front();
                    check("bus_addr", bus_addr, b.addr);
                    check("bus_we", bus_we, b.we);
                    check("bus_be", bus_be, b.be);
                    if (b.we) check("bus_wdata", bus_wdata, b.wdata);
                end
            end
            if (resp_valid) begin
                if (resp_q.size() == 0) begin
                    check("unexpected_resp_valid", 1, 0);
                end else begin
                    resp_t r;
                    r = resp_q.pop_front();
                    check("resp_rdata", resp_rdata, r.rdata);
                    check("bus_err", bus_err, r.err);
                    check("resp_stall", stall, 0);
                    check("stall_cycles", 32'(stall_run), 32'(r.stalls));
                    check("bus_req_cycles", 32'(req_run), 32'(r.reqs));
                    $display("txn: rdata=0x%08h err=%0b stall_cycles=%0d", resp_rdata, bus_err, stall_run);
                end
                stall_run = 0;
                req_run   = 0;
            end
            if (stall) stall_run++;
            if (bus_req) req_run++;
            req_prev = bus_req;
        end
    end

    initial begin
        repeat (2) step();
        @(negedge clk);
        check("rst_bus_req", bus_req, 0);
        check("rst_bus_we", bus_we, 0);
        check("rst_bus_addr", bus_addr, 0);
        check("rst_bus_be", bus_be, 0);
        check("rst_bus_wdata", bus_wdata, 0);
        check("rst_resp_valid", resp_valid, 0);
        check("rst_resp_rdata", resp_rdata, 0);
        check("rst_bus_err", bus_err, 0);
        check("rst_stall", stall, 0);
        step();
        reset = 1'b0;

        do_access(1'b0, 2'b00, 1'b1, 32'h0000_1003, 32'h0, 32'h80FF_1234, 1);
        do_access(1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 0);
        do_access(1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0, 32'h8001_7FFF, 2);
        do_access(1'b1, 2'b00, 1'b0, 32'h0000_0031, 32'h1234_56AB, 32'hDEAD_BEEF, 0);
        do_misaligned(1'b1, 2'b10, 32'h0000_0041);
        do_misaligned(1'b0, 2'b01, 32'h0000_0043);
        do_misaligned(1'b0, 2'b11, 32'h0000_0040);
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_5000, 32'h0, 32'h1234_5678, TO + 1);
        do_access(1'b0, 2'b10, 1'b0, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, TO - 1);

        for (int n = 0; n < 40; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = 2'($urandom_range(0, 2));
            a  = $urandom;
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            do_access(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
                      int'($urandom_range(0, TO + 1)));
        end
        for (int n = 0; n < 4; n++) begin
            logic [31:0] a;
            a = $urandom;
            a[0] = 1'b1;
            do_misaligned(1'($urandom), 2'($urandom_range(1, 2)), a);
        end

        // Reset in the middle of BUSY; the late ack must be ignored.
        begin
            bus_t b;
            b.addr = 32'h0000_7000; b.we = 1'b0; b.be = 4'b0000; b.wdata = '0;
            bus_q.push_back(b);
            step();
            req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0000_7000;
            step();
            req_valid = 1'b0;
            step();
            reset = 1'b1;
            step();
            reset = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h1111_2222;
            @(negedge clk);
            check("rst_mid_bus_req", bus_req, 0);
            check("rst_mid_stall", stall, 0);
            step();
            bus_ack = 1'b0;
            @(negedge clk);
            check("rst_mid_no_resp", resp_valid, 0);
            repeat (2) step();
            do_access(1'b1, 2'b01, 1'b0, 32'h0000_8002, 32'hAAAA_5A5A, 32'h0, 1);
        end

        repeat (3) step();
        check("resp_queue_drained", 32'(resp_q.size()), 0);
        check("bus_queue_drained", 32'(bus_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
